// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Address and control sequencer for an in-place radix-2 decimation-in-frequency
// FFT. For each of the LOGN stages it issues N/2 butterfly operations. Each
// operation names two data RAM addresses and a twiddle index. Between stages
// it can optionally idle for the butterfly pipeline latency, so that the last
// writes of a stage land before the next stage reads them.
//
// Optional feature: define FFT_SEQ_DRAIN_EN to insert a BF_LAT-cycle DRAIN gap
// after every non-final stage. Without it the next stage starts directly.
//
// Parameters:
//   N      FFT length (power of two, >= 8)
//   LOGN   log2(N)
//   BF_LAT butterfly pipeline latency in cycles (1..15)
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     begin one transform (only honoured in IDLE)
//   bf_ready  butterfly datapath accepts the current operation
//   bf_valid  addr_a/addr_b/tw_idx/stage describe a valid operation
//   addr_a    upper-leg data address
//   addr_b    lower-leg data address
//   tw_idx    twiddle coefficient index
//   stage     current stage number
//   busy      high in RUN and DRAIN
//   done      one-cycle completion pulse
//
// Handshake: an operation is consumed on a rising edge where bf_valid and
// bf_ready are both high. While bf_valid is high and bf_ready is low, every
// output holds its value. bf_valid never drops without a handshake.
module fft_stage_sequencer #(
  parameter int N      = 128,
  parameter int LOGN   = 7,
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            bf_ready,
  output logic            bf_valid,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic [3:0]      stage,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
`ifdef FFT_SEQ_DRAIN_EN
  localparam logic [1:0] DRAIN = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0]      LAST_STAGE = 4'(LOGN - 1);
  localparam logic [LOGN-2:0] K_LAST     = (LOGN-1)'(N / 2 - 1);
  localparam logic [LOGN-2:0] K_ONE      = (LOGN-1)'(1);
  localparam logic [LOGN-1:0] L_ONE      = LOGN'(1);

  // Elaboration-time guard against inconsistent parameters.
  if ((N != (1 << LOGN)) || (LOGN < 3) || (BF_LAT < 1) || (BF_LAT > 15)) begin : g_param_check
    $error("fft_stage_sequencer: illegal parameter combination");
  end

  logic [1:0]      state;
  logic [3:0]      stage_q;
  logic [LOGN-2:0] k;

`ifdef FFT_SEQ_DRAIN_EN
  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);
  logic [3:0] drain_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stage_q <= 4'd0;
      k       <= '0;
`ifdef FFT_SEQ_DRAIN_EN
      drain_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            stage_q <= 4'd0;
            k       <= '0;
          end
        end
        RUN: begin
          if (bf_ready) begin
            if (k == K_LAST) begin
              k <= '0;
              if (stage_q == LAST_STAGE) begin
                state <= DONE;
              end else begin
`ifdef FFT_SEQ_DRAIN_EN
                // Stage number stays on the old value while draining.
                state     <= DRAIN;
                drain_cnt <= 4'd0;
`else
                stage_q <= stage_q + 4'd1;
`endif
              end
            end else begin
              k <= k + K_ONE;
            end
          end
        end
`ifdef FFT_SEQ_DRAIN_EN
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= RUN;
            stage_q   <= stage_q + 4'd1;
            drain_cnt <= 4'd0;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
`endif
        DONE: begin
          // start is ignored here; IDLE samples it on the next cycle.
          state   <= IDLE;
          stage_q <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // DIF addressing without a divider.
  // span = N >> (stage+1), so span-1 = (N/2-1) >> stage is a low-bit mask of k:
  //   j        = k & mask                (position inside the group)
  //   grp*span = k & ~mask               (group base, already scaled by span)
  //   addr_a   = 2*(k & ~mask) + j
  //   addr_b   = addr_a + span
  //   tw_idx   = j << stage              (always < N/2 because j < span)
  // ---------------------------------------------------------------------------
  logic [LOGN-2:0] mask;
  logic [LOGN-2:0] j;
  logic [LOGN-2:0] hi;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] a_calc;
  logic [LOGN-2:0] tw_calc;
  logic            run;

  always_comb begin
    mask    = K_LAST >> stage_q;
    j       = k & mask;
    hi      = k & ~mask;
    span    = {1'b0, mask} + L_ONE;
    a_calc  = {hi, 1'b0} | {1'b0, j};
    tw_calc = j << stage_q;
    run     = (state == RUN);
  end

  always_comb begin
    bf_valid = run;
    addr_a   = run ? a_calc : '0;
    addr_b   = run ? (a_calc + span) : '0;
    tw_idx   = run ? tw_calc : '0;
    stage    = stage_q;
    done     = (state == DONE);
`ifdef FFT_SEQ_DRAIN_EN
    busy     = run || (state == DRAIN);
`else
    busy     = run;
`endif
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
// Self-checking bench for fft_stage_sequencer with N=8, LOGN=3, BF_LAT=2.
// A transaction-level reference model holds the ordered list of butterfly
// operations one transform must produce. It also tracks whether the sequencer
// is idle, issuing, gapping between stages, or signalling completion. The DUT
// outputs are compared against that model on every negative clock edge.
// Directed sequences pin exact cycle counts. Randomized start/ready/reset
// traffic then follows.
module tb_fft_stage_sequencer;

  localparam int N      = 8;
  localparam int LOGN   = 3;
  localparam int BF_LAT = 2;
`ifdef FFT_SEQ_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif
  localparam int W = 4 + LOGN + LOGN + (LOGN - 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            bf_ready = 1'b1;
  logic            bf_valid;
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [LOGN-2:0] tw_idx;
  logic [3:0]      stage;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N(N), .LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bf_ready (bf_ready),
    .bf_valid (bf_valid),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .tw_idx   (tw_idx),
    .stage    (stage),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // One operation, computed straight from the DIF definition with div/mod.
  function automatic logic [W-1:0] model_op(input int s, input int kk);
    int span, grp, jj, a, b, tw;
    span = N >> (s + 1);
    grp  = kk / span;
    jj   = kk % span;
    a    = 2 * grp * span + jj;
    b    = a + span;
    tw   = jj * (1 << s);
    return {4'(s), LOGN'(a), LOGN'(b), (LOGN-1)'(tw)};
  endfunction

  logic [W-1:0] exp_q[$];
  int m_mode = 0;   // 0 idle, 1 transform in progress, 2 completion cycle
  int m_gap  = 0;   // remaining inter-stage idle cycles
  bit cmp_en = 1'b0;

  task automatic fill_ops();
    exp_q.delete();
    for (int s = 0; s < LOGN; s++)
      for (int kk = 0; kk < N / 2; kk++)
        exp_q.push_back(model_op(s, kk));
  endtask

  // Model advance on each rising edge using the inputs the DUT samples.
  initial begin
    logic [W-1:0] op;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0;
        m_gap  = 0;
        exp_q.delete();
      end else begin
        case (m_mode)
          0: if (start) begin fill_ops(); m_mode = 1; m_gap = 0; end
          1: begin
            if (m_gap > 0) m_gap--;
            else if (bf_ready) begin
              op = exp_q.pop_front();
              if (exp_q.size() == 0) m_mode = 2;
              else if (DRAIN_EN && (exp_q[0][W-1 -: 4] != op[W-1 -: 4])) m_gap = BF_LAT;
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // Compare process: every negative edge once enabled.
  initial begin
    logic [W-1:0] h;
    bit e_valid;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_valid = (m_mode == 1) && (m_gap == 0);
        check("bf_valid", {31'd0, bf_valid}, {31'd0, e_valid});
        check("busy", {31'd0, busy}, {31'd0, m_mode == 1});
        check("done", {31'd0, done}, {31'd0, m_mode == 2});
        if (e_valid && exp_q.size() > 0) begin
          h = exp_q[0];
          check("stage", {28'd0, stage}, {28'd0, h[W-1 -: 4]});
          check("addr_a", 32'(addr_a), 32'(h[W-5 -: LOGN]));
          check("addr_b", 32'(addr_b), 32'(h[W-5-LOGN -: LOGN]));
          check("tw_idx", 32'(tw_idx), 32'(h[LOGN-2:0]));
        end
        if (m_mode == 0)
          check("idle_outputs", 32'({addr_a, addr_b, tw_idx, stage}), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Literal expectations for the model's operation table (N=8).
  int lit_a  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int lit_b  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int lit_tw [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  initial begin
    logic [W-1:0] op;
    int valid_cnt, busy_cnt, done_at, first_valid, hold_cnt, stall_left, done_cnt;
    bit stalled, found;

    // Pin the reference model against the hand-derived table.
    for (int i = 0; i < 12; i++) begin
      op = model_op(i / 4, i % 4);
      check("model_a", 32'(op[W-5 -: LOGN]), 32'(lit_a[i]));
      check("model_b", 32'(op[W-5-LOGN -: LOGN]), 32'(lit_b[i]));
      check("model_tw", 32'(op[LOGN-2:0]), 32'(lit_tw[i]));
    end

    // Reset
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bf_valid, busy, done, addr_a, addr_b, tw_idx, stage}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single transform, ready always high: cycle-exact timing.
    pulse_start();
    valid_cnt = 0; busy_cnt = 0; done_at = 0; first_valid = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bf_valid) begin
        valid_cnt++;
        if (first_valid == 0) first_valid = c;
      end
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    check("first_valid_cycle", 32'(first_valid), 32'd1);
    check("valid_cycles", 32'(valid_cnt), 32'd12);
    check("busy_cycles", 32'(busy_cnt), DRAIN_EN ? 32'd16 : 32'd12);
    check("done_cycle", 32'(done_at), DRAIN_EN ? 32'd17 : 32'd13);

    // Three-cycle stall on the stage-1 operation (4,6,0).
    pulse_start();
    hold_cnt = 0; done_at = 0; stall_left = 0; stalled = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bf_valid && stage == 4'd1 && addr_a == 3'd4) begin
        hold_cnt++;
        check("stall_hold_b", 32'(addr_b), 32'd6);
        check("stall_hold_tw", 32'(tw_idx), 32'd0);
      end
      if (done && done_at == 0) done_at = c;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bf_ready = 1'b1;
      end else if (!stalled && bf_valid && stage == 4'd1 && addr_a == 3'd4) begin
        stalled = 1'b1;
        bf_ready = 1'b0;
        stall_left = 3;
      end
      @(negedge clk);
    end
    bf_ready = 1'b1;
    check("stall_hold_cycles", 32'(hold_cnt), 32'd4);
    check("stall_done_cycle", 32'(done_at), DRAIN_EN ? 32'd20 : 32'd16);

    // Reset in the middle of stage 1, then restart.
    pulse_start();
    found = 1'b0;
    for (int c = 1; c <= 30 && !found; c++) begin
      if (bf_valid && stage == 4'd1 && addr_a == 3'd1) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_stage1_k1", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", 32'({bf_valid, busy, done, addr_a, addr_b, tw_idx, stage}), 32'd0);
    rst = 1'b0;
    pulse_start();
    check("restart_first_op", 32'({bf_valid, addr_a, addr_b, tw_idx, stage}),
          32'({1'b1, 3'd0, 3'd4, 2'd0, 4'd0}));
    repeat (30) @(negedge clk);

    // start held high: back-to-back transforms, each separated by IDLE.
    start = 1'b1;
    @(negedge clk);
    done_cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_start_done_count", 32'(done_cnt), DRAIN_EN ? 32'd2 : 32'd3);
    repeat (40) @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bf_ready = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; bf_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter N, default 128, FFT length (power of two, >= 8).
REQ-002 SHALL have parameter LOGN, default 7, log2(N).
REQ-003 SHALL have parameter BF_LAT, default 4, butterfly pipeline latency in cycles (1..15).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request to begin one N-point transform.
REQ-007 SHALL have port bf_ready  input  1  butterfly datapath accepts the current operation.
REQ-008 SHALL have port bf_valid  output  1  addr_a/addr_b/tw_idx/stage hold a valid butterfly operation.
REQ-009 SHALL have port addr_a  output  LOGN  upper-leg data RAM address.
REQ-010 SHALL have port addr_b  output  LOGN  lower-leg data RAM address.
REQ-011 SHALL have port tw_idx  output  LOGN-1  twiddle coefficient index into the coefficient table.
REQ-012 SHALL have port stage  output  4  current stage number, 0..LOGN-1.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse on transform completion.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 -> RUN with stage=0, butterfly counter k=0; bf_valid=1 in the cycle after start is sampled.
REQ-017 start SHALL be ignored outside IDLE (no queuing, no restart).
REQ-018 RUN, radix-2 DIF addressing: span=N>>(stage+1); j=k mod span; grp=k div span; addr_a=2*grp*span+j; addr_b=addr_a+span; tw_idx=j<<stage; all shift/mask based, no divider.
REQ-019 Handshake: operation advances only on bf_valid&&bf_ready; while bf_ready=0, all outputs SHALL hold stable.
REQ-020 k counts 0..N/2-1 per stage; on handshake at k=N/2-1: if stage<LOGN-1 -> next stage (per REQ-026/027) with k=0; if stage=LOGN-1 -> DONE.
REQ-021 DONE: done=1, busy=0, bf_valid=0 for exactly one cycle, then IDLE; start in DONE ignored.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-023 bf_valid SHALL be 1 only in RUN.
REQ-024 tw_idx SHALL never exceed N/2-1; addr_b SHALL never exceed N-1.

Reset
REQ-025 rst=1 at any time, including mid-transform or mid-stall, SHALL force IDLE next cycle with bf_valid=0, busy=0, done=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, k=0, drain counter=0; rst has priority over start.

Configuration
REQ-026 With macro FFT_SEQ_DRAIN_EN defined: after last handshake of a non-final stage, enter DRAIN for exactly BF_LAT cycles (bf_valid=0, stage shows old value), then RUN with stage+1, k=0; no DRAIN after the final stage.
REQ-027 Without FFT_SEQ_DRAIN_EN: DRAIN state and counter SHALL not be built; next stage begins in the cycle after the last handshake (bf_valid stays 1).

Verification (N=8, LOGN=3, BF_LAT=2, bf_ready=1 unless stated)
REQ-028 Stage 0 sequence -> (a,b,tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3); stage 1 -> (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 -> (0,1,0),(2,3,0),(4,5,0),(6,7,0).
REQ-029 Start pulse, no macro -> 12 consecutive bf_valid cycles, done pulse in 13th cycle after start sampled, busy high cycles 1..12.
REQ-030 Start pulse, FFT_SEQ_DRAIN_EN -> two 2-cycle bf_valid=0 gaps between stages, done in 17th cycle.
REQ-031 bf_ready=0 for 3 cycles at stage 1 k=2 -> outputs hold (4,6,0) for 4 cycles, then continue with (5,7,2); done delayed by 3 cycles.
REQ-032 rst asserted at stage 1 k=1 -> next cycle IDLE, all outputs 0; subsequent start restarts at (0,4,0), stage 0.
REQ-033 start held high throughout -> ignored while busy/DONE; new transform begins in the cycle after DONE's return to IDLE samples start.
